ysyx_24090012_mem_arbiter: RTL and testbench

Parametrised N-master to 1-slave memory arbiter replacing the fixed two-port (IFU/LSU) shared SRAM front end. Each master issues single read/write requests over a valid/ready request channel and receives data over a valid/ready response channel. The arbiter serialises requests to one downstream memory port with fixed-priority or round-robin arbitration. A per-transaction response timeout returns an error response instead of hanging the core.

---
 rtl/ysyx_24090012_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ysyx_24090012_mem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090012_mem_arbiter.sv
// N-master to 1-slave memory arbiter: one outstanding transaction, fixed or round-robin grant,
// with a response timeout that returns an error and drains the late slave response.
module ysyx_24090012_mem_arbiter #(
  parameter int unsigned       NUM_MST     = 2,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ARB_MODE    = 1,
  parameter int unsigned       TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(32'hDEADBEEF)
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [NUM_MST-1:0]                                 m_req_valid,
  input  logic [NUM_MST-1:0]                                 m_req_wen,
  input  logic [NUM_MST*ADDR_W-1:0]                          m_req_addr,
  input  logic [NUM_MST*DATA_W-1:0]                          m_req_wdata,
  input  logic [NUM_MST*(DATA_W/8)-1:0]                      m_req_wmask,
  output logic [NUM_MST-1:0]                                 m_req_ready,
  output logic [NUM_MST-1:0]                                 m_resp_valid,
  output logic [DATA_W-1:0]                                  m_resp_rdata,
  output logic                                               m_resp_err,
  input  logic [NUM_MST-1:0]                                 m_resp_ready,
  output logic                                               s_req_valid,
  output logic                                               s_req_wen,
  output logic [ADDR_W-1:0]                                  s_req_addr,
  output logic [DATA_W-1:0]                                  s_req_wdata,
  output logic [DATA_W/8-1:0]                                s_req_wmask,
  input  logic                                               s_req_ready,
  input  logic                                               s_resp_valid,
  input  logic [DATA_W-1:0]                                  s_resp_rdata,
  input  logic                                               s_resp_err,
  output logic                                               s_resp_ready,
  output logic                                               busy,
  output logic [((NUM_MST > 1) ? $clog2(NUM_MST) : 1)-1:0]   grant_id
);

  localparam int unsigned IW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int unsigned MW = DATA_W / 8;
  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0] TCNT_LAST = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, RET} state_e;

  state_e            state_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     grant_q;
  logic              drain_q;
  logic [CW-1:0]     tcnt_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MW-1:0]     wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [IW-1:0]     win_idx_d;
  logic [IW-1:0]     scan_idx;
  logic              win_vld_d;
  logic              accept;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_MST) sum = sum - NUM_MST;
    return IW'(sum);
  endfunction

  // First requester in scan order: from index 0 (fixed) or from rr_ptr upward (round-robin)
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_MST; k++) begin
      scan_idx = (ARB_MODE == 0) ? IW'(k) : wrap_add(rr_ptr_q, k);
      if (!win_vld_d && m_req_valid[scan_idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = scan_idx;
      end
    end
  end

  assign accept       = rst && (state_q == IDLE) && !drain_q && win_vld_d;
  assign m_req_ready  = accept ? (NUM_MST'(1) << win_idx_d) : '0;
  assign m_resp_valid = (state_q == RET) ? (NUM_MST'(1) << grant_q) : '0;
  assign m_resp_rdata = rdata_q;
  assign m_resp_err   = err_q;
  assign s_req_valid  = (state_q == REQ);
  assign s_req_wen    = wen_q;
  assign s_req_addr   = addr_q;
  assign s_req_wdata  = wdata_q;
  assign s_req_wmask  = wmask_q;
  assign s_resp_ready = (state_q == RESP) || drain_q;
  assign busy         = (state_q != IDLE);
  assign grant_id     = grant_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      drain_q  <= 1'b0;
      tcnt_q   <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // The first response after a timeout belongs to the abandoned transaction and is dropped
      if (drain_q && s_resp_valid) drain_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= REQ;
            grant_q <= win_idx_d;
            wen_q   <= m_req_wen[win_idx_d];
            addr_q  <= m_req_addr[32'(win_idx_d) * ADDR_W +: ADDR_W];
            wdata_q <= m_req_wdata[32'(win_idx_d) * DATA_W +: DATA_W];
            wmask_q <= m_req_wmask[32'(win_idx_d) * MW +: MW];
          end
        end
        REQ: begin
          if (s_req_ready) begin
            state_q <= RESP;
            tcnt_q  <= '0;
          end
        end
        RESP: begin
          if (s_resp_valid) begin
            rdata_q <= s_resp_rdata;
            err_q   <= s_resp_err;
            state_q <= RET;
          end else if (TO_EN && (tcnt_q == TCNT_LAST)) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
            drain_q <= 1'b1;
            state_q <= RET;
          end else begin
            tcnt_q <= tcnt_q + CW'(1);
          end
        end
        RET: begin
          if (m_resp_ready[grant_q]) begin
            state_q <= IDLE;
            if (ARB_MODE != 0) rr_ptr_q <= wrap_add(grant_q, 1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24090012_mem_arbiter.sv
// Directed bench for the memory arbiter: cycle vector table plus hand-written
// arbitration, backpressure, timeout/drain and reset sequences.
module tb_ysyx_24090012_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req_valid, m_req_wen, m_resp_ready;
  logic [63:0] m_req_addr, m_req_wdata;
  logic [7:0]  m_req_wmask;
  logic        s_req_ready, s_resp_valid, s_resp_err;
  logic [31:0] s_resp_rdata;

  logic [1:0]  m_req_ready, m_resp_valid;
  logic [31:0] m_resp_rdata, s_req_addr, s_req_wdata;
  logic        m_resp_err, s_req_valid, s_req_wen, s_resp_ready, busy;
  logic [3:0]  s_req_wmask;
  logic [0:0]  grant_id;

  logic [1:0]  fx_m_req_ready, fx_m_resp_valid;
  logic [31:0] fx_m_resp_rdata, fx_s_req_addr, fx_s_req_wdata;
  logic        fx_m_resp_err, fx_s_req_valid, fx_s_req_wen, fx_s_resp_ready, fx_busy;
  logic [3:0]  fx_s_req_wmask;
  logic [0:0]  fx_grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_24090012_mem_arbiter #(.NUM_MST(2), .ARB_MODE(1), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .m_req_valid(m_req_valid), .m_req_wen(m_req_wen),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_req_ready(m_req_ready), .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
    .m_resp_err(m_resp_err), .m_resp_ready(m_resp_ready), .s_req_valid(s_req_valid),
    .s_req_wen(s_req_wen), .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
    .s_req_wmask(s_req_wmask), .s_req_ready(s_req_ready), .s_resp_valid(s_resp_valid),
    .s_resp_rdata(s_resp_rdata), .s_resp_err(s_resp_err), .s_resp_ready(s_resp_ready),
    .busy(busy), .grant_id(grant_id));

  ysyx_24090012_mem_arbiter #(.NUM_MST(2), .ARB_MODE(0), .TIMEOUT_CYC(0)) dut_fx (
    .clk(clk), .rst(rst), .m_req_valid(m_req_valid), .m_req_wen(m_req_wen),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_req_ready(fx_m_req_ready), .m_resp_valid(fx_m_resp_valid), .m_resp_rdata(fx_m_resp_rdata),
    .m_resp_err(fx_m_resp_err), .m_resp_ready(m_resp_ready), .s_req_valid(fx_s_req_valid),
    .s_req_wen(fx_s_req_wen), .s_req_addr(fx_s_req_addr), .s_req_wdata(fx_s_req_wdata),
    .s_req_wmask(fx_s_req_wmask), .s_req_ready(s_req_ready), .s_resp_valid(s_resp_valid),
    .s_resp_rdata(s_resp_rdata), .s_resp_err(s_resp_err), .s_resp_ready(fx_s_resp_ready),
    .busy(fx_busy), .grant_id(fx_grant_id));

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [1:0]  w;
    logic        srdy;
    logic        srv;
    logic [31:0] sd;
    logic        se;
    logic [1:0]  mrr;
    logic [1:0]  e_mreq;
    logic        e_sreqv;
    logic        e_srr;
    logic [1:0]  e_mrv;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_busy;
    logic        e_grant;
    logic        e_wen;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] addr_c  [2];
  logic [31:0] wdata_c [2];
  logic [3:0]  wmask_c [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] v, input logic [1:0] w, input logic srdy,
                     input logic srv, input logic [31:0] sd, input logic se, input logic [1:0] mrr);
    @(negedge clk);
    rst = r; m_req_valid = v; m_req_wen = w; s_req_ready = srdy;
    s_resp_valid = srv; s_resp_rdata = sd; s_resp_err = se; m_resp_ready = mrr;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
  endtask

  logic [0:0] rr_g [4];
  logic [0:0] fx_g [4];
  int         nr, nf;

  initial begin
    rst = 1'b0; m_req_valid = '0; m_req_wen = '0; m_resp_ready = '0;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp_rdata = '0; s_resp_err = 1'b0;
    addr_c[0]  = 32'h8000_0000; wdata_c[0] = 32'hCAFE_0000; wmask_c[0] = 4'b1111;
    addr_c[1]  = 32'h8000_1000; wdata_c[1] = 32'h1234_ABCD; wmask_c[1] = 4'b0011;
    m_req_addr  = {addr_c[1], addr_c[0]};
    m_req_wdata = {wdata_c[1], wdata_c[0]};
    m_req_wmask = {wmask_c[1], wmask_c[0]};
    repeat (2) @(posedge clk);

    // rst v w srdy srv sd se mrr | mreq sreqv srr mrv rdata err busy grant wen
    tbl[0]  = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 32'h0010_0073, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 32'h0010_0073, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 32'h0010_0073, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 32'h0010_0073, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 32'h0010_0073, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 32'h0010_0073, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 32'h0010_0073, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].w, tbl[i].srdy, tbl[i].srv, tbl[i].sd, tbl[i].se, tbl[i].mrr);
      chk($sformatf("vec%0d_outs", i),
          64'({m_req_ready, s_req_valid, s_resp_ready, m_resp_valid, m_resp_rdata, m_resp_err, busy, grant_id}),
          64'({tbl[i].e_mreq, tbl[i].e_sreqv, tbl[i].e_srr, tbl[i].e_mrv, tbl[i].e_rdata,
               tbl[i].e_err, tbl[i].e_busy, tbl[i].e_grant}));
      if (tbl[i].e_sreqv) begin
        chk($sformatf("vec%0d_wen_addr", i), 64'({s_req_wen, s_req_addr}),
            64'({tbl[i].e_wen, addr_c[tbl[i].e_grant]}));
        chk($sformatf("vec%0d_wdata_mask", i), 64'({s_req_wdata, s_req_wmask}),
            64'({wdata_c[tbl[i].e_grant], wmask_c[tbl[i].e_grant]}));
      end
    end

    // Both masters continuously requesting: round-robin alternates, fixed priority starves M1
    do_reset();
    nr = 0; nf = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 32'h5555_0000, 1'b0, 2'b11);
      if (s_req_valid && nr < 4) begin rr_g[nr] = grant_id; nr++; end
      if (fx_s_req_valid && nf < 4) begin fx_g[nf] = fx_grant_id; nf++; end
    end
    chk("arb_rr_count", 64'(nr), 64'd4);
    chk("arb_fx_count", 64'(nf), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < nr) chk($sformatf("arb_rr_grant%0d", i), 64'(rr_g[i]), 64'(i % 2));
      if (i < nf) chk($sformatf("arb_fx_grant%0d", i), 64'(fx_g[i]), 64'd0);
    end

    // Backpressure in RET with M1 waiting
    do_reset();
    cyc(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    chk("bp_accept", 64'(m_req_ready), 64'b01);
    cyc(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 2'b00);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
      chk($sformatf("bp_hold%0d", c), 64'({m_resp_valid, m_resp_rdata, m_resp_err, busy, m_req_ready}),
          64'({2'b01, 32'hA5A5_0001, 1'b0, 1'b1, 2'b00}));
    end
    cyc(1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b01);
    chk("bp_handshake", 64'({m_resp_valid, m_req_ready}), 64'({2'b01, 2'b00}));
    cyc(1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    chk("bp_next_grant", 64'({m_resp_valid, m_req_ready}), 64'({2'b00, 2'b10}));

    // Silent slave: timeout error, then a late response is drained before M0 is served
    do_reset();
    cyc(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    chk("to_accept", 64'(m_req_ready), 64'b01);
    cyc(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    for (int c = 0; c < 4; c++) begin
      cyc(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
      chk($sformatf("to_wait%0d", c), 64'({s_resp_ready, m_resp_valid}), 64'({1'b1, 2'b00}));
    end
    cyc(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b01);
    chk("to_err_resp", 64'({m_resp_valid, m_resp_rdata, m_resp_err}), 64'({2'b01, 32'hDEAD_BEEF, 1'b1}));
    for (int c = 0; c < 2; c++) begin
      cyc(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
      chk($sformatf("to_drain%0d", c), 64'({m_req_ready, s_resp_ready, busy}), 64'({2'b00, 1'b1, 1'b0}));
    end
    cyc(1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 2'b00);
    chk("to_late_resp", 64'({m_req_ready, s_resp_ready, m_resp_valid}), 64'({2'b00, 1'b1, 2'b00}));
    cyc(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    chk("to_after_drain", 64'({m_req_ready, m_resp_valid, m_resp_rdata}), 64'({2'b01, 2'b00, 32'hDEAD_BEEF}));

    // Response on the timeout cycle wins, then reset abandons an in-flight M1 read
    do_reset();
    cyc(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    for (int c = 0; c < 3; c++) cyc(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b1, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b01);
    chk("race_resp", 64'({m_resp_valid, m_resp_rdata, m_resp_err}), 64'({2'b01, 32'h0BAD_F00D, 1'b1}));
    cyc(1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    chk("race_no_drain", 64'({m_req_ready, s_resp_ready}), 64'({2'b10, 1'b0}));
    cyc(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
    chk("rst_pre_req", 64'({s_req_valid, grant_id, s_req_addr}), 64'({1'b1, 1'b1, 32'h8000_1000}));
    cyc(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    chk("rst_pre_resp", 64'(s_resp_ready), 64'd1);
    cyc(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    cyc(1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 32'h7777_7777, 1'b0, 2'b00);
    chk("rst_outs", 64'({busy, s_resp_ready, s_req_valid, m_resp_valid, grant_id, m_resp_err, m_resp_rdata}),
        64'({1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0}));
    chk("rst_payload", 64'({s_req_addr, s_req_wdata}), 64'h0);
    chk("rst_rr_ptr", 64'(m_req_ready), 64'b01);
    cyc(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 32'h7777_7777, 1'b0, 2'b11);
    chk("rst_late_ignored", 64'({m_resp_valid, m_resp_rdata}), 64'({2'b00, 32'h0}));

    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
